dmem_pipe: RTL and testbench

- Parametrised successor to the single-cycle data memory: byte-addressed, big-endian, 32-bit data port with a valid/ready request channel.
- Adds a configurable pipelined read latency, sign/zero-extended sub-word loads, alignment and range fault detection, and optional zero-fill after reset.
- Sits between the MEM stage of the pipeline and backing storage; the MEM stage stalls on req_ready=0.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_if.sv | 26 ++
 rtl/dmem_resp_pipe.sv | 29 ++
 rtl/dmem_pipe.sv | 115 +++++++++++
 tb/tb_dmem_pipe.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the pipelined data memory: access sizes, FSM encoding,
// response pipeline entry and the access fault check.
package dmem_pkg;

  localparam logic [1:0] DSIZE_BYTE = 2'b00;
  localparam logic [1:0] DSIZE_HALF = 2'b01;
  localparam logic [1:0] DSIZE_ILL  = 2'b10;
  localparam logic [1:0] DSIZE_WORD = 2'b11;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic        fault;
    logic [0:31] rdata;
  } resp_t;

  // The end-of-access address is formed in 33 bits so a large address cannot
  // wrap around into the valid range.
  function automatic logic access_fault(input logic [1:0]  dsize,
                                        input logic [0:31] addr,
                                        input logic [32:0] size);
    logic        bad_size;
    logic        misalign;
    logic [32:0] last;
    bad_size = (dsize == DSIZE_ILL);
    misalign = ((dsize == DSIZE_HALF) && addr[31]) ||
               ((dsize == DSIZE_WORD) && (addr[30:31] != 2'b00));
    last     = {1'b0, addr} + {31'b0, dsize};
    return bad_size || misalign || (last >= size);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response channel between the MEM stage (master) and the data memory (slave).
interface dmem_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [0:31] req_addr;
  logic [0:31] req_wdata;
  logic [0:1]  req_dsize;
  logic        req_signed;
  logic        resp_valid;
  logic [0:31] resp_rdata;
  logic        resp_fault;
  logic        resp_write;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_dsize, req_signed,
    input  req_ready, resp_valid, resp_rdata, resp_fault, resp_write
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_dsize, req_signed,
    output req_ready, resp_valid, resp_rdata, resp_fault, resp_write
  );

endinterface

// File: rtl/dmem_resp_pipe.sv
// Fixed-depth response delay line; one entry enters per cycle, the oldest leaves
// LATENCY cycles later.
module dmem_resp_pipe
  import dmem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  resp_t entry,
  output resp_t head
);

  resp_t stage [LATENCY];

  // NOTE: every stage is cleared by the async reset so a reset drops all
  // in-flight responses instantly; sequential state uses non-blocking updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= entry;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign head = stage[LATENCY-1];

endmodule

// File: rtl/dmem_pipe.sv
// Byte-addressed big-endian data memory with pipelined read latency, sub-word
// access with extension, fault detection and optional zero-fill after reset.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int SIZE           = 32768,
  parameter int LATENCY        = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  dmem_if.slave bus
);

  localparam int              AW        = $clog2(SIZE);
  localparam int              CW        = AW - 2;
  localparam logic [CW-1:0]   LAST_WORD = CW'(SIZE / 4 - 1);
  localparam logic [32:0]     SIZE_33   = 33'(SIZE);

  logic [7:0]    mem [SIZE];
  logic [0:0]    state;
  logic [CW-1:0] fill_cnt;

  logic          accept;
  logic          fault;
  logic          do_store;
  logic [AW-1:0] idx;
  logic [7:0]    b0, b1, b2, b3;
  logic          ext;
  logic [0:31]   load_data;
  resp_t         entry;
  resp_t         head;

  assign bus.req_ready = (state == ST_RUN);
  assign accept        = bus.req_valid && bus.req_ready;
  assign fault         = access_fault(bus.req_dsize, bus.req_addr, SIZE_33);
  assign do_store      = accept && bus.req_write && !fault;
  assign idx           = bus.req_addr[32-AW:31];

  // INIT always lasts at least one cycle so req_ready is low while in reset;
  // without zero-fill it hands over to RUN on the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      fill_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (!CLEAR_ON_RESET || fill_cnt == LAST_WORD) state <= ST_RUN;
      fill_cnt <= fill_cnt + CW'(1);
    end
  end

  // NOTE: the storage array has no reset branch; contents survive reset and
  // only the INIT sweep clears them, one word per cycle.
  always_ff @(posedge clk) begin
    if (state == ST_INIT && CLEAR_ON_RESET) begin
      for (int i = 0; i < 4; i++) mem[{fill_cnt, 2'(i)}] <= 8'h00;
    end else if (do_store) begin
      case (bus.req_dsize)
        DSIZE_WORD: begin
          mem[idx]          <= bus.req_wdata[0:7];
          mem[idx + AW'(1)] <= bus.req_wdata[8:15];
          mem[idx + AW'(2)] <= bus.req_wdata[16:23];
          mem[idx + AW'(3)] <= bus.req_wdata[24:31];
        end
        DSIZE_HALF: begin
          mem[idx]          <= bus.req_wdata[16:23];
          mem[idx + AW'(1)] <= bus.req_wdata[24:31];
        end
        default: mem[idx] <= bus.req_wdata[24:31];
      endcase
    end
  end

  // Read lanes; out-of-range lanes are only ever used for faulted requests,
  // whose data is forced to zero below.
  assign b0 = mem[idx];
  assign b1 = mem[idx + AW'(1)];
  assign b2 = mem[idx + AW'(2)];
  assign b3 = mem[idx + AW'(3)];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    load_data = '0;
    ext       = bus.req_signed && b0[7];
    case (bus.req_dsize)
      DSIZE_BYTE: load_data = {{24{ext}}, b0};
      DSIZE_HALF: load_data = {{16{ext}}, b0, b1};
      DSIZE_WORD: load_data = {b0, b1, b2, b3};
      default:    load_data = '0;
    endcase
  end

  always_comb begin
    entry       = '0;
    entry.valid = accept;
    entry.write = accept && bus.req_write;
    entry.fault = accept && fault;
    if (accept && !bus.req_write && !fault) entry.rdata = load_data;
  end

  dmem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .entry (entry),
    .head  (head)
  );

  assign bus.resp_valid = head.valid;
  assign bus.resp_write = head.write;
  assign bus.resp_fault = head.fault;
  assign bus.resp_rdata = head.rdata;

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench: DUT A (zero-fill, latency 2) runs a vector table; DUT B
// (no fill, latency 3) covers exact latency, mid-flight reset and data retention.
module tb_dmem_pipe;
  import dmem_pkg::*;

  localparam int SIZE  = 64;
  localparam int LAT_A = 2;
  localparam int LAT_B = 3;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_if ifa ();
  dmem_if ifb ();

  dmem_pipe #(.SIZE(SIZE), .LATENCY(LAT_A), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .bus   (ifa)
  );

  dmem_pipe #(.SIZE(SIZE), .LATENCY(LAT_B), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .bus   (ifb)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  dsize;
    logic        sgn;
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [1:0] ds, input logic sg,
                              input logic [31:0] er, input logic ef);
    vec_t v;
    v.name = n; v.wr = wr; v.addr = a; v.wdata = wd; v.dsize = ds; v.sgn = sg;
    v.exp_rdata = er; v.exp_fault = ef;
    return v;
  endfunction

  task automatic drive_a(input vec_t v);
    ifa.req_valid  = 1'b1;
    ifa.req_write  = v.wr;
    ifa.req_addr   = v.addr;
    ifa.req_wdata  = v.wdata;
    ifa.req_dsize  = v.dsize;
    ifa.req_signed = v.sgn;
  endtask

  task automatic idle_a();
    ifa.req_valid = 1'b0; ifa.req_write = 1'b0; ifa.req_addr = '0;
    ifa.req_wdata = '0;   ifa.req_dsize = '0;   ifa.req_signed = 1'b0;
  endtask

  task automatic drive_b(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] ds, input logic sg);
    ifb.req_valid  = 1'b1;
    ifb.req_write  = wr;
    ifb.req_addr   = a;
    ifb.req_wdata  = wd;
    ifb.req_dsize  = ds;
    ifb.req_signed = sg;
  endtask

  task automatic idle_b();
    ifb.req_valid = 1'b0; ifb.req_write = 1'b0; ifb.req_addr = '0;
    ifb.req_wdata = '0;   ifb.req_dsize = '0;   ifb.req_signed = 1'b0;
  endtask

  // Back-to-back issue on DUT A; vector t is expected at the sample LAT_A cycles later.
  task automatic run_table();
    int n = tbl.size();
    for (int t = 0; t < n + LAT_A; t++) begin
      if (t >= LAT_A) begin
        vec_t v;
        v = tbl[t - LAT_A];
        check({v.name, " valid"}, ifa.resp_valid, 32'd1);
        check({v.name, " rdata"}, ifa.resp_rdata, v.exp_rdata);
        check({v.name, " fault"}, ifa.resp_fault, v.exp_fault);
        check({v.name, " write"}, ifa.resp_write, v.wr);
      end else begin
        check("a pipe empty", ifa.resp_valid, 32'd0);
      end
      if (t < n) drive_a(tbl[t]);
      else       idle_a();
      @(negedge clk);
    end
    check("a drained", ifa.resp_valid, 32'd0);
  endtask

  // Single request on DUT B with exact-latency check.
  task automatic b_xfer(input string name, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] ds, input logic sg,
                        input logic [31:0] er, input logic ef);
    drive_b(wr, a, wd, ds, sg);
    @(negedge clk);
    idle_b();
    for (int k = 1; k < LAT_B; k++) begin
      check({name, " early"}, ifb.resp_valid, 32'd0);
      @(negedge clk);
    end
    check({name, " valid"}, ifb.resp_valid, 32'd1);
    check({name, " rdata"}, ifb.resp_rdata, er);
    check({name, " fault"}, ifb.resp_fault, ef);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int low;
    idle_a();
    idle_b();
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    #1;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    #1;
    check("rst a ready", ifa.req_ready,  32'd0);
    check("rst a valid", ifa.resp_valid, 32'd0);
    check("rst a rdata", ifa.resp_rdata, 32'd0);
    check("rst a fault", ifa.resp_fault, 32'd0);
    check("rst a write", ifa.resp_write, 32'd0);
    check("rst b ready", ifb.req_ready,  32'd0);
    repeat (3) @(negedge clk);
    check("rst held a ready", ifa.req_ready, 32'd0);
    check("rst held b ready", ifb.req_ready, 32'd0);

    // Zero-fill: count sampled cycles with req_ready low after release.
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    #1;
    low = 0;
    while (ifa.req_ready !== 1'b1 && low < 100) begin
      low++;
      @(negedge clk);
      #1;
    end
    check("init ready-low cycles", low, 32'd16);
    check("b ready without fill", ifb.req_ready, 32'd1);
    @(negedge clk);

    tbl.push_back(mk("st_w_10",    1'b1, 32'h10, 32'hDEADBEEF, DSIZE_WORD, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk("ld_w_10",    1'b0, 32'h10, 32'h0, DSIZE_WORD, 1'b0, 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk("ld_b_11_s",  1'b0, 32'h11, 32'h0, DSIZE_BYTE, 1'b1, 32'hFFFFFFAD, 1'b0));
    tbl.push_back(mk("ld_b_11_u",  1'b0, 32'h11, 32'h0, DSIZE_BYTE, 1'b0, 32'h000000AD, 1'b0));
    tbl.push_back(mk("ld_h_12_s",  1'b0, 32'h12, 32'h0, DSIZE_HALF, 1'b1, 32'hFFFFBEEF, 1'b0));
    tbl.push_back(mk("ld_h_10_u",  1'b0, 32'h10, 32'h0, DSIZE_HALF, 1'b0, 32'h0000DEAD, 1'b0));
    tbl.push_back(mk("ld_b_10_s",  1'b0, 32'h10, 32'h0, DSIZE_BYTE, 1'b1, 32'hFFFFFFDE, 1'b0));
    tbl.push_back(mk("ld_h_12_u",  1'b0, 32'h12, 32'h0, DSIZE_HALF, 1'b0, 32'h0000BEEF, 1'b0));
    tbl.push_back(mk("ld_w_10b",   1'b0, 32'h10, 32'h0, DSIZE_WORD, 1'b1, 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk("st_h_20",    1'b1, 32'h20, 32'h00001234, DSIZE_HALF, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk("st_b_23",    1'b1, 32'h23, 32'h000000AB, DSIZE_BYTE, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk("ld_w_20",    1'b0, 32'h20, 32'h0, DSIZE_WORD, 1'b0, 32'h123400AB, 1'b0));
    tbl.push_back(mk("ld_h_22_s",  1'b0, 32'h22, 32'h0, DSIZE_HALF, 1'b1, 32'h000000AB, 1'b0));
    tbl.push_back(mk("ld_w_02",    1'b0, 32'h02, 32'h0, DSIZE_WORD, 1'b0, 32'h0, 1'b1));
    tbl.push_back(mk("ld_ds2",     1'b0, 32'h04, 32'h0, DSIZE_ILL,  1'b0, 32'h0, 1'b1));
    tbl.push_back(mk("ld_h_11",    1'b0, 32'h11, 32'h0, DSIZE_HALF, 1'b0, 32'h0, 1'b1));
    tbl.push_back(mk("st_w_3e",    1'b1, 32'h3E, 32'h11223344, DSIZE_WORD, 1'b0, 32'h0, 1'b1));
    tbl.push_back(mk("ld_w_3c",    1'b0, 32'h3C, 32'h0, DSIZE_WORD, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk("ld_h_3e",    1'b0, 32'h3E, 32'h0, DSIZE_HALF, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk("st_b_40",    1'b1, 32'h40, 32'h00000055, DSIZE_BYTE, 1'b0, 32'h0, 1'b1));
    tbl.push_back(mk("ld_b_40",    1'b0, 32'h40, 32'h0, DSIZE_BYTE, 1'b0, 32'h0, 1'b1));
    tbl.push_back(mk("ld_b_ffff",  1'b0, 32'hFFFFFFFF, 32'h0, DSIZE_BYTE, 1'b0, 32'h0, 1'b1));
    tbl.push_back(mk("ld_w_fffc",  1'b0, 32'hFFFFFFFC, 32'h0, DSIZE_WORD, 1'b0, 32'h0, 1'b1));
    tbl.push_back(mk("st_b_3f",    1'b1, 32'h3F, 32'h0000007F, DSIZE_BYTE, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk("ld_b_3f_s",  1'b0, 32'h3F, 32'h0, DSIZE_BYTE, 1'b1, 32'h0000007F, 1'b0));
    tbl.push_back(mk("ld_w_3c_b",  1'b0, 32'h3C, 32'h0, DSIZE_WORD, 1'b0, 32'h0000007F, 1'b0));
    run_table();

    // DUT B: exact latency 3, then reset with loads in flight.
    b_xfer("b_st_w_08", 1'b1, 32'h08, 32'hCAFEF00D, DSIZE_WORD, 1'b0, 32'h0, 1'b0);
    b_xfer("b_ld_w_08", 1'b0, 32'h08, 32'h0, DSIZE_WORD, 1'b0, 32'hCAFEF00D, 1'b0);
    b_xfer("b_ld_b_0b", 1'b0, 32'h0B, 32'h0, DSIZE_BYTE, 1'b0, 32'h0000000D, 1'b0);

    drive_b(1'b0, 32'h08, 32'h0, DSIZE_WORD, 1'b0);
    @(negedge clk);
    drive_b(1'b0, 32'h09, 32'h0, DSIZE_BYTE, 1'b1);
    @(negedge clk);
    drive_b(1'b0, 32'h0A, 32'h0, DSIZE_BYTE, 1'b1);
    @(negedge clk);
    idle_b();
    check("mid first valid", ifb.resp_valid, 32'd1);
    check("mid first rdata", ifb.resp_rdata, 32'hCAFEF00D);
    rst_b_n = 1'b0;
    #1;
    check("mid rst valid", ifb.resp_valid, 32'd0);
    check("mid rst rdata", ifb.resp_rdata, 32'd0);
    check("mid rst ready", ifb.req_ready,  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_b_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no stale resp", ifb.resp_valid, 32'd0);
    end
    check("b ready after rst", ifb.req_ready, 32'd1);
    b_xfer("b_survive", 1'b0, 32'h08, 32'h0, DSIZE_WORD, 1'b0, 32'hCAFEF00D, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
